// File: rtl/sysid_arb_pkg.sv
// rtl/sysid_arb_pkg.sv - shared types, constants and helpers for the system-ID read arbiter
package sysid_arb_pkg;

    // Arbiter FSM: accept a request, present the address to the slave, return data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Slave word map: word 0 is the ID, word 1 is the build timestamp.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Width of a requester index; never below 1 bit so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sysid_read_arbiter_rr_pick.sv
// rtl/sysid_read_arbiter_rr_pick.sv - combinational round-robin priority picker
module rr_pick
    import sysid_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // One extra bit so ptr + offset cannot overflow before the wrap subtraction.
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan offsets from furthest to nearest so the lowest index at or above the
    // pointer (wrapping) is the last one written and therefore wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysid_read_arbiter.sv
// rtl/sysid_read_arbiter.sv - round-robin read arbiter in front of the system-ID slave (optional check: SYSID_READ_ARBITER_CHECK_EN)
module sysid_read_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int                N_REQ       = 4,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] EXPECTED_ID = DATA_W'(32'h0000_0000),
    parameter logic [DATA_W-1:0] EXPECTED_TS = DATA_W'(32'h6193_6AD2)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_address,
    output logic [N_REQ-1:0]          req_waitrequest,
    output logic [N_REQ*DATA_W-1:0]   req_readdata,
    output logic [N_REQ-1:0]          req_readdatavalid,
    output logic                      sys_address,
    input  logic [DATA_W-1:0]         sys_readdata,
    output logic                      id_mismatch
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_win;
    logic [DATA_W-1:0] r_data;
    logic [N_REQ-1:0]  r_rdv;
    logic              r_sys_addr;

    logic [IDX_W-1:0]  w_win;
    logic              w_any;
    logic              w_accept;
    logic [N_REQ-1:0]  w_grant;
    logic [N_REQ-1:0]  w_win_onehot;
    logic [IDX_W-1:0]  w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (req_read),
        .i_ptr   (r_ptr),
        .o_idx   (w_win),
        .o_valid (w_any)
    );

    // A request is taken only in IDLE; reset blocks acceptance so every stall stays high.
    assign w_accept = (r_state == IDLE) && !reset && w_any;

    // Decode the live winner into the per-requester accept strobe.
    always_comb begin
        w_grant = '0;
        if (w_accept) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign req_waitrequest = ~w_grant;

    // One-hot of the latched winner, used to steer the data-valid pulse.
    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[r_win] = 1'b1;
    end

    assign w_ptr_next = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    // Only the slice of the requester currently being answered carries data.
    always_comb begin
        req_readdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_rdv[i]) begin
                req_readdata[i*DATA_W +: DATA_W] = r_data;
            end
        end
    end

    assign req_readdatavalid = r_rdv;
    assign sys_address       = r_sys_addr;

    // Arbiter FSM with registered slave address, captured data and valid pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_data     <= '0;
            r_rdv      <= '0;
            r_sys_addr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdv <= '0;
                    if (w_any) begin
                        r_win      <= w_win;
                        r_sys_addr <= req_address[w_win];
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_data     <= sys_readdata;
                    r_sys_addr <= 1'b0;
                    r_rdv      <= w_win_onehot;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_rdv   <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: begin
                    r_rdv      <= '0;
                    r_sys_addr <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

`ifdef SYSID_READ_ARBITER_CHECK_EN
    logic r_mismatch;
    logic w_check_fail;

    // The slave word being read is selected by the latched address still on sys_address.
    assign w_check_fail = (r_sys_addr == ADDR_TS) ? (sys_readdata != EXPECTED_TS)
                                                  : (sys_readdata != EXPECTED_ID);

    // Sticky flag: set as the data is captured so it is visible in the response cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (r_state == ISSUE && w_check_fail) begin
            r_mismatch <= 1'b1;
        end
    end

    assign id_mismatch = r_mismatch;
`else
    assign id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// tb/tb_sysid_read_arbiter.sv - scoreboard bench for the system-ID read arbiter
module tb_sysid_read_arbiter;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h6193_6AD2;
`ifdef SYSID_READ_ARBITER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_read;
    logic [3:0]   req_address;
    logic [3:0]   req_waitrequest;
    logic [127:0] req_readdata;
    logic [3:0]   req_readdatavalid;
    logic         sys_address;
    logic [31:0]  sys_readdata;
    logic         id_mismatch;

    logic [31:0]  id_val;
    logic [31:0]  ts_val;

    always #5 clock = ~clock;

    assign sys_readdata = sys_address ? ts_val : id_val;

    sysid_read_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .req_read          (req_read),
        .req_address       (req_address),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .sys_address       (sys_address),
        .sys_readdata      (sys_readdata),
        .id_mismatch       (id_mismatch)
    );

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    int          rdv_cyc[$];
    logic [31:0] last_rd;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int   m_state = 0;
    int   m_ptr   = 0;
    int   m_win   = 0;
    logic m_addr  = 1'b0;
    logic m_mis   = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [3:0]  ew;
        logic [3:0]  erdv;
        logic [31:0] d;
        int          acc;
        exp_t        e;
        ew  = 4'hF;
        acc = -1;
        if (!reset && m_state == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (acc < 0 && req_read[(m_ptr + k) % 4]) acc = (m_ptr + k) % 4;
            end
            if (acc >= 0) ew[acc] = 1'b0;
        end
        chk("waitrequest", {124'd0, req_waitrequest}, {124'd0, ew});
        chk("sys_address", {127'd0, sys_address}, {127'd0, (m_state == 1) ? m_addr : 1'b0});
        chk("id_mismatch", {127'd0, id_mismatch}, {127'd0, m_mis});
        erdv = 4'h0;
        if (m_state == 2) erdv[m_win] = 1'b1;
        chk("readdatavalid", {124'd0, req_readdatavalid}, {124'd0, erdv});
        if (req_readdatavalid != 4'h0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rdv", {124'd0, req_readdatavalid}, 128'd0);
            end else begin
                e = sbq.pop_front();
                chk("rdv_cycle", 128'(cyc), 128'(e.due));
                chk("rdv_owner", {124'd0, req_readdatavalid}, 128'(1) << e.idx);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("readdata[%0d]", i), {96'd0, req_readdata[i*32 +: 32]},
                        {96'd0, (i == e.idx) ? e.data : 32'd0});
                end
                last_rd = req_readdata[e.idx*32 +: 32];
                grant_log.push_back(e.idx);
                rdv_cyc.push_back(cyc);
            end
        end else begin
            chk("readdata_idle", req_readdata, 128'd0);
        end
        if (reset) begin
            m_state = 0;
            m_ptr   = 0;
            m_mis   = 1'b0;
            sbq.delete();
        end else begin
            case (m_state)
                0: if (acc >= 0) begin
                    m_win   = acc;
                    m_addr  = req_address[acc];
                    m_state = 1;
                end
                1: begin
                    d = m_addr ? ts_val : id_val;
                    if (CHK && d != (m_addr ? EXP_TS : EXP_ID)) m_mis = 1'b1;
                    sbq.push_back('{idx: m_win, data: d, due: cyc + 1});
                    m_state = 2;
                end
                default: begin
                    m_ptr   = (m_win + 1) % 4;
                    m_state = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        #1;
        check_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic r, input logic [3:0] rd, input logic [3:0] ad, input int n);
        reset       = r;
        req_read    = rd;
        req_address = ad;
        for (int i = 0; i < n; i++) step();
    endtask

    int base;
    int t0;

    initial begin
        reset       = 1'b1;
        req_read    = 4'h0;
        req_address = 4'h0;
        id_val      = EXP_ID;
        ts_val      = EXP_TS;
        last_rd     = 32'd0;
        @(posedge clock);
        #1;

        // reset state, with a pending read that must still see waitrequest high
        drive(1'b1, 4'h0, 4'h0, 1);
        drive(1'b1, 4'h1, 4'h0, 1);
        chk("reset_readdata", req_readdata, 128'd0);

        // single read from requester 2, timestamp word
        base = grant_log.size();
        t0   = cyc;
        drive(1'b0, 4'b0100, 4'b0100, 1);
        drive(1'b0, 4'b0000, 4'b0000, 4);
        chk("single_count", 128'(grant_log.size() - base), 128'd1);
        chk("single_grant", 128'(grant_log[base]), 128'd2);
        chk("single_latency", 128'(rdv_cyc[base] - t0), 128'd2);
        chk("single_data", {96'd0, last_rd}, {96'd0, EXP_TS});

        // contention: all four hold read from reset
        drive(1'b1, 4'hF, 4'b1010, 1);
        base = grant_log.size();
        drive(1'b0, 4'hF, 4'b1010, 17);
        drive(1'b0, 4'h0, 4'h0, 4);
        chk("contend_count", 128'(grant_log.size() - base), 128'd6);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("contend_grant%0d", k), 128'(grant_log[base + k]), 128'(k % 4));
        end
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("contend_gap%0d", k), 128'(rdv_cyc[base + k] - rdv_cyc[base + k - 1]), 128'd3);
        end

        // fairness: requester 1 reasserts in RESP while 3 waits
        drive(1'b1, 4'h0, 4'h0, 1);
        base = grant_log.size();
        drive(1'b0, 4'b0010, 4'b0000, 1);
        drive(1'b0, 4'b1000, 4'b0000, 1);
        drive(1'b0, 4'b1010, 4'b0000, 2);
        drive(1'b0, 4'b0010, 4'b0000, 3);
        drive(1'b0, 4'b0000, 4'b0000, 4);
        chk("fair_count", 128'(grant_log.size() - base), 128'd3);
        chk("fair_g0", 128'(grant_log[base]), 128'd1);
        chk("fair_g1", 128'(grant_log[base + 1]), 128'd3);
        chk("fair_g2", 128'(grant_log[base + 2]), 128'd1);

        // reset in the ISSUE cycle of a read from requester 0
        drive(1'b1, 4'h0, 4'h0, 1);
        drive(1'b0, 4'b0010, 4'h0, 1);
        drive(1'b0, 4'b0000, 4'h0, 3);
        base = grant_log.size();
        drive(1'b0, 4'b0001, 4'h0, 1);
        drive(1'b1, 4'b0000, 4'h0, 1);
        drive(1'b1, 4'b0110, 4'h0, 1);
        chk("reset_wait", {124'd0, req_waitrequest}, {124'd0, 4'hF});
        drive(1'b0, 4'b0110, 4'h0, 1);
        drive(1'b0, 4'b0000, 4'h0, 4);
        chk("rst_count", 128'(grant_log.size() - base), 128'd1);
        chk("rst_grant", 128'(grant_log[base]), 128'd1);

        // wrong ID word, then a matching timestamp read
        id_val = 32'h0000_0001;
        drive(1'b1, 4'h0, 4'h0, 1);
        drive(1'b0, 4'b0001, 4'b0000, 1);
        drive(1'b0, 4'b0000, 4'b0000, 3);
        chk("mis_data", {96'd0, last_rd}, {96'd0, 32'h0000_0001});
        drive(1'b0, 4'b0100, 4'b0100, 1);
        drive(1'b0, 4'b0000, 4'b0000, 4);
        chk("mis_sticky", {127'd0, id_mismatch}, {127'd0, CHK});
        chk("mis_ts_data", {96'd0, last_rd}, {96'd0, EXP_TS});
        drive(1'b1, 4'h0, 4'h0, 1);
        drive(1'b0, 4'h0, 4'h0, 1);
        chk("mis_cleared", {127'd0, id_mismatch}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
